// File: rtl/memory_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The master holds address, data and op steady while dmemRequest is high.
interface memory_stage_if;
  logic        dmemRequest;
  logic        dmemWrite;
  logic [31:0] dmemAddress;
  logic [31:0] dmemWriteData;
  logic [31:0] dmemReadData;
  logic        dmemReady;

  modport master (
    output dmemRequest, dmemWrite, dmemAddress, dmemWriteData,
    input  dmemReadData, dmemReady
  );

  modport slave (
    input  dmemRequest, dmemWrite, dmemAddress, dmemWriteData,
    output dmemReadData, dmemReady
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: variable-latency data-memory access feeding the MEM/WB register,
// with upstream stall, misalignment detection and memory timeout.
module memory_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  registerWriteIn,
  input  logic                  memoryToRegisterIn,
  input  logic                  memoryWriteIn,
  input  logic                  memoryReadIn,
  input  logic [31:0]           ALUresultIn,
  input  logic [31:0]           writeDataIn,
  input  logic [4:0]            writeRegisterIn,
  memory_stage_if.master        dmem,
  output logic                  stall,
  output logic                  registerWriteOut,
  output logic                  memoryToRegisterOut,
  output logic [31:0]           readDataOut,
  output logic [31:0]           ALUresultOut,
  output logic [4:0]            writeRegisterOut,
  output logic                  alignError,
  output logic                  busError
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Latched access and the control it carries through the wait
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        lat_rw_q, lat_rw_d;
  logic        lat_m2r_q, lat_m2r_d;
  logic [4:0]  lat_dest_q, lat_dest_d;

  // MEM/WB register
  logic        rw_out_q, rw_out_d;
  logic        m2r_out_q, m2r_out_d;
  logic [31:0] rdata_out_q, rdata_out_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [4:0]  dest_out_q, dest_out_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;

  logic mem_op;
  logic aligned;

  assign mem_op  = memoryReadIn | memoryWriteIn;
  assign aligned = (ALUresultIn[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_rw_d    = lat_rw_q;
    lat_m2r_d   = lat_m2r_q;
    lat_dest_d  = lat_dest_q;
    // MEM/WB defaults to a bubble every cycle
    rw_out_d    = 1'b0;
    m2r_out_d   = 1'b0;
    rdata_out_d = 32'd0;
    alu_out_d   = 32'd0;
    dest_out_d  = 5'd0;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          rw_out_d   = registerWriteIn;
          m2r_out_d  = memoryToRegisterIn;
          alu_out_d  = ALUresultIn;
          dest_out_d = writeRegisterIn;
        end else if (!aligned) begin
          align_err_d = 1'b1;
        end else begin
          stall      = 1'b1;
          addr_d     = ALUresultIn;
          wdata_d    = writeDataIn;
          wr_d       = memoryWriteIn;  // read+write together is a store
          lat_rw_d   = registerWriteIn;
          lat_m2r_d  = memoryToRegisterIn;
          lat_dest_d = writeRegisterIn;
          req_d      = 1'b1;
          cnt_d      = 8'd0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (dmem.dmemReady) begin
          rw_out_d    = lat_rw_q;
          m2r_out_d   = lat_m2r_q;
          alu_out_d   = addr_q;
          dest_out_d  = lat_dest_q;
          rdata_out_d = wr_q ? 32'd0 : dmem.dmemReadData;
          req_d       = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      lat_rw_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_dest_q  <= 5'd0;
      rw_out_q    <= 1'b0;
      m2r_out_q   <= 1'b0;
      rdata_out_q <= 32'd0;
      alu_out_q   <= 32'd0;
      dest_out_q  <= 5'd0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_rw_q    <= lat_rw_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_dest_q  <= lat_dest_d;
      rw_out_q    <= rw_out_d;
      m2r_out_q   <= m2r_out_d;
      rdata_out_q <= rdata_out_d;
      alu_out_q   <= alu_out_d;
      dest_out_q  <= dest_out_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign dmem.dmemRequest   = req_q;
  assign dmem.dmemWrite     = wr_q;
  assign dmem.dmemAddress   = addr_q;
  assign dmem.dmemWriteData = wdata_q;

  assign registerWriteOut    = rw_out_q;
  assign memoryToRegisterOut = m2r_out_q;
  assign readDataOut         = rdata_out_q;
  assign ALUresultOut        = alu_out_q;
  assign writeRegisterOut    = dest_out_q;
  assign alignError          = align_err_q;
  assign busError            = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized transactions
// compared against a transaction-level model of the stage's timing and results.
module tb_memory_stage;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        registerWriteIn, memoryToRegisterIn, memoryWriteIn, memoryReadIn;
  logic [31:0] ALUresultIn, writeDataIn;
  logic [4:0]  writeRegisterIn;
  logic        stall;
  logic        registerWriteOut, memoryToRegisterOut;
  logic [31:0] readDataOut, ALUresultOut;
  logic [4:0]  writeRegisterOut;
  logic        alignError, busError;

  memory_stage_if bus();

  memory_stage #(.TIMEOUT(T)) dut (
    .clock               (clock),
    .reset               (reset),
    .registerWriteIn     (registerWriteIn),
    .memoryToRegisterIn  (memoryToRegisterIn),
    .memoryWriteIn       (memoryWriteIn),
    .memoryReadIn        (memoryReadIn),
    .ALUresultIn         (ALUresultIn),
    .writeDataIn         (writeDataIn),
    .writeRegisterIn     (writeRegisterIn),
    .dmem                (bus),
    .stall               (stall),
    .registerWriteOut    (registerWriteOut),
    .memoryToRegisterOut (memoryToRegisterOut),
    .readDataOut         (readDataOut),
    .ALUresultOut        (ALUresultOut),
    .writeRegisterOut    (writeRegisterOut),
    .alignError          (alignError),
    .busError            (busError)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_inputs();
    registerWriteIn    = 1'($urandom);
    memoryToRegisterIn = 1'($urandom);
    memoryWriteIn      = 1'($urandom);
    memoryReadIn       = 1'($urandom);
    ALUresultIn        = $urandom;
    writeDataIn        = $urandom;
    writeRegisterIn    = 5'($urandom);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d);
    memoryReadIn       = rd;
    memoryWriteIn      = wr;
    registerWriteIn    = rw;
    memoryToRegisterIn = m2r;
    ALUresultIn        = a;
    writeDataIn        = wd;
    writeRegisterIn    = d;
  endtask

  task automatic bubble_check(input string tag);
    chk1 ({tag, " regWrOut"}, registerWriteOut, 1'b0);
    chk1 ({tag, " m2rOut"},   memoryToRegisterOut, 1'b0);
    chk32({tag, " rdOut"},    readDataOut, 32'd0);
    chk32({tag, " aluOut"},   ALUresultOut, 32'd0);
    chk32({tag, " destOut"},  32'(writeRegisterOut), 32'd0);
  endtask

  // Non-memory op: one-cycle pass-through, never stalls.
  task automatic alu_op(input logic rw, input logic m2r, input logic [31:0] a, input logic [4:0] d);
    drive(1'b0, 1'b0, rw, m2r, a, $urandom, d);
    bus.dmemReady    = 1'($urandom);
    bus.dmemReadData = $urandom;
    #1 chk1("alu stall", stall, 1'b0);
    tick();
    chk1 ("alu regWrOut", registerWriteOut, rw);
    chk1 ("alu m2rOut", memoryToRegisterOut, m2r);
    chk32("alu aluOut", ALUresultOut, a);
    chk32("alu destOut", 32'(writeRegisterOut), 32'(d));
    chk32("alu rdOut", readDataOut, 32'd0);
    chk1 ("alu req", bus.dmemRequest, 1'b0);
    chk1 ("alu alignErr", alignError, 1'b0);
    chk1 ("alu busErr", busError, 1'b0);
    $display("txn alu addr=%h dest=%0d rw=%b", a, d, rw);
  endtask

  // Misaligned memory op: no request, bubble, one-cycle alignError.
  task automatic misaligned_op(input logic rd, input logic wr, input logic [31:0] a);
    drive(rd, wr, 1'b1, rd, a, $urandom, 5'($urandom_range(1, 31)));
    bus.dmemReady = 1'($urandom);
    #1 chk1("mis stall", stall, 1'b0);
    tick();
    chk1("mis req", bus.dmemRequest, 1'b0);
    bubble_check("mis");
    chk1("mis alignErr", alignError, 1'b1);
    chk1("mis busErr", busError, 1'b0);
    $display("txn misaligned addr=%h rd=%b wr=%b", a, rd, wr);
  endtask

  // Aligned memory op; lat = WAIT cycles with dmemReady low before it rises.
  // Completes iff lat < T, otherwise aborts after T-1 low WAIT cycles.
  task automatic mem_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                        input logic [31:0] rdat, input int lat);
    int  n_wait;
    bit  done;
    bit  is_store;
    int  stall_cycles;
    is_store     = wr;
    done         = (lat < T);
    n_wait       = done ? lat : T - 1;
    stall_cycles = 0;
    drive(rd, wr, rw, m2r, a, wd, d);
    bus.dmemReady    = 1'($urandom);
    bus.dmemReadData = $urandom;
    #1 chk1("mem accept stall", stall, 1'b1);
    if (stall) stall_cycles++;
    tick();
    for (int i = 0; i <= n_wait; i++) begin
      chk1 ("mem req", bus.dmemRequest, 1'b1);
      chk1 ("mem dmemWrite", bus.dmemWrite, is_store);
      chk32("mem dmemAddress", bus.dmemAddress, a);
      chk32("mem dmemWriteData", bus.dmemWriteData, wd);
      bubble_check("mem wait");
      chk1 ("mem wait alignErr", alignError, 1'b0);
      chk1 ("mem wait busErr", busError, 1'b0);
      rand_inputs();
      bus.dmemReady    = (i == lat);
      bus.dmemReadData = (i == lat) ? rdat : $urandom;
      #1 chk1("mem wait stall", stall, i != n_wait);
      if (stall) stall_cycles++;
      tick();
    end
    chk1("mem req drop", bus.dmemRequest, 1'b0);
    chk1("mem alignErr", alignError, 1'b0);
    chk32("mem stall cycles", 32'(stall_cycles), 32'(1 + n_wait));
    if (done) begin
      chk1 ("mem regWrOut", registerWriteOut, rw);
      chk1 ("mem m2rOut", memoryToRegisterOut, m2r);
      chk32("mem aluOut", ALUresultOut, a);
      chk32("mem destOut", 32'(writeRegisterOut), 32'(d));
      chk32("mem rdOut", readDataOut, is_store ? 32'd0 : rdat);
      chk1 ("mem busErr", busError, 1'b0);
    end else begin
      bubble_check("mem timeout");
      chk1("mem timeout busErr", busError, 1'b1);
    end
    $display("txn mem %s addr=%h lat=%0d stalls=%0d %s", is_store ? "store" : "load",
             a, lat, stall_cycles, done ? "done" : "timeout");
  endtask

  initial begin
    logic [31:0] a;
    int          kind;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    bus.dmemReady    = 1'b0;
    bus.dmemReadData = 32'd0;
    tick();
    tick();
    chk1 ("rst req", bus.dmemRequest, 1'b0);
    chk1 ("rst dmemWrite", bus.dmemWrite, 1'b0);
    chk32("rst dmemAddress", bus.dmemAddress, 32'd0);
    chk32("rst dmemWriteData", bus.dmemWriteData, 32'd0);
    bubble_check("rst");
    chk1 ("rst alignErr", alignError, 1'b0);
    chk1 ("rst busErr", busError, 1'b0);
    chk1 ("rst stall", stall, 1'b0);
    $display("txn reset");
    reset = 1'b0;

    // Directed cases
    alu_op(1'b1, 1'b0, 32'h0000_1234, 5'd5);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, 5'd7, 32'hDEAD_BEEF, 3);
    mem_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 32'h5555_AAAA, 0);
    misaligned_op(1'b1, 1'b0, 32'h0000_0102);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd9, 32'h1234_5678, 50);
    mem_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0808, 32'h0BAD_F00D, 5'd3, 32'hFFFF_0000, T - 1);
    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0810, 32'h0, 5'd4, 32'hA5A5_5A5A, T);

    // Reset during the second WAIT cycle, then a late dmemReady
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd6);
    bus.dmemReady = 1'b0;
    tick();
    rand_inputs();
    tick();
    reset = 1'b1;
    tick();
    chk1("rstwait req", bus.dmemRequest, 1'b0);
    bubble_check("rstwait");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    reset            = 1'b0;
    bus.dmemReady    = 1'b1;
    bus.dmemReadData = 32'hBEEF_CAFE;
    #1 chk1("rstwait stall", stall, 1'b0);
    tick();
    chk1("rstwait late req", bus.dmemRequest, 1'b0);
    bubble_check("rstwait late");
    chk1("rstwait alignErr", alignError, 1'b0);
    chk1("rstwait busErr", busError, 1'b0);
    $display("txn reset-in-wait");
    alu_op(1'b1, 1'b0, 32'h0000_ABCD, 5'd12);

    // Randomized back-to-back traffic
    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      case (kind)
        0: alu_op(1'($urandom), 1'($urandom), a, 5'($urandom));
        1: begin
          if (a[1:0] == 2'b00) a[1:0] = 2'($urandom_range(1, 3));
          misaligned_op(1'($urandom), 1'b1, a);
        end
        2: begin
          a[1:0] = 2'b00;
          mem_op(1'b1, 1'b0, 1'($urandom), 1'b1, a, $urandom, 5'($urandom), $urandom,
                 int'($urandom_range(0, T + 1)));
        end
        default: begin
          a[1:0] = 2'b00;
          mem_op(1'($urandom), 1'b1, 1'b0, 1'b0, a, $urandom, 5'($urandom), $urandom,
                 int'($urandom_range(0, T + 1)));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
